// File: rtl/afifo_frame_reader_pkg.sv
// Shared types and widths for the frame reader slice.
// Latency: n/a (declarations only).
// Backpressure: n/a. State GAP exists only with AFIFO_FRAME_READER_IFG_EN.
package afifo_frame_reader_pkg;

  localparam int DATA_W      = 8;
  localparam int FIFO_CNT_W  = 12;
  localparam int FRAME_CNT_W = 16;
  localparam int OBUF_DEPTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_WAIT_LAST = 2'd2
`ifdef AFIFO_FRAME_READER_IFG_EN
    ,
    ST_GAP       = 2'd3
`endif
  } state_t;

  // One output-buffer slot: byte plus end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } obuf_ent_t;

endpackage

// File: rtl/afifo_frame_reader_if.sv
// AXI4-Stream byte channel carrying frames out of the reader.
// Latency: n/a (wires only).
// Backpressure: standard tvalid/tready; master holds tdata/tlast while stalled.
interface afifo_frame_reader_if;
  import afifo_frame_reader_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/afifo_frame_reader_obuf.sv
// 3-entry register FIFO of {last, data}; head entry is always slot 0.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must never push when full or pop when empty.
module frame_reader_obuf
  import afifo_frame_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  obuf_ent_t  din,
  input  logic       pop,
  output obuf_ent_t  head,
  output logic [1:0] occ
);

  obuf_ent_t  ent     [OBUF_DEPTH];
  obuf_ent_t  ent_nxt [OBUF_DEPTH];
  logic [1:0] wr_idx;
  logic [1:0] occ_nxt;

  // Next contents: shift toward the head on pop, then land a push in the first free slot.
  always_comb begin
    ent_nxt = ent;
    wr_idx  = occ;
    occ_nxt = occ;
    if (pop) begin
      for (int i = 0; i < OBUF_DEPTH - 1; i++) ent_nxt[i] = ent[i + 1];
      ent_nxt[OBUF_DEPTH - 1] = '0;
      wr_idx = occ - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (wr_idx == 2'(i)) ent_nxt[i] = din;
      end
    end
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Register the buffer; entries clear so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) ent[i] <= '0;
      occ <= '0;
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) ent[i] <= ent_nxt[i];
      occ <= occ_nxt;
    end
  end

  assign head = ent[0];

endmodule

// File: rtl/afifo_frame_reader.sv
// Drains the async byte FIFO in fixed FRAME_LEN frames onto AXI-Stream with tlast; optional IFG idle gap via AFIFO_FRAME_READER_IFG_EN.
// Latency: first rd_en the cycle after a qualifying count is seen; first tvalid 2 cycles after first rd_en.
// Backpressure: reads throttled so buffered+in-flight bytes never exceed 3; no combinational path from tready to rd_en.
module afifo_frame_reader
  import afifo_frame_reader_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int IFG       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      fifo_dout,
  input  logic                   fifo_empty,
  input  logic [FIFO_CNT_W-1:0]  fifo_rd_data_count,
  output logic                   fifo_rd_en,
  afifo_frame_reader_if.master   m_axis,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  localparam logic [11:0] LEN    = 12'(FRAME_LEN);
  localparam logic [11:0] LEN_M1 = 12'(FRAME_LEN - 1);
  // An illegal parameterisation leaves the reader inert rather than misframing.
  localparam bit PARAMS_OK = (FRAME_LEN >= 1) && (FRAME_LEN <= 2048) && (IFG >= 1) && (IFG <= 255);

  state_t     state;
  logic [10:0] issued;
  logic [10:0] rcvd;
  logic        inflight;
  logic [1:0]  occ;
  obuf_ent_t   head;
  obuf_ent_t   din;
  logic        pop;
  logic        last_hs;
`ifdef AFIFO_FRAME_READER_IFG_EN
  logic [7:0]  gap_cnt;
`endif

  // Read only when the buffer can absorb every byte already requested plus this one.
  assign fifo_rd_en = PARAMS_OK && (state == ST_READ) && !fifo_empty &&
                      ({1'b0, issued} < LEN) &&
                      (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

  assign m_axis.tvalid = (occ != 2'd0);
  assign m_axis.tdata  = head.data;
  assign m_axis.tlast  = head.last;
  assign pop           = m_axis.tvalid && m_axis.tready;
  assign last_hs       = pop && m_axis.tlast;

  assign din.data = fifo_dout;
  assign din.last = ({1'b0, rcvd} == LEN_M1);

  // Track the one-cycle read latency and count returned bytes to tag the frame's last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      rcvd     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) rcvd <= din.last ? 11'd0 : rcvd + 11'd1;
    end
  end

  frame_reader_obuf u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (din),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  // Frame sequencing: qualify, issue FRAME_LEN reads, wait for tlast to drain, optional gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      issued    <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
`ifdef AFIFO_FRAME_READER_IFG_EN
      gap_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rd_data_count >= LEN) begin
            state  <= ST_READ;
            issued <= '0;
            busy   <= 1'b1;
          end
        end
        ST_READ: begin
          if (fifo_rd_en) begin
            issued <= issued + 11'd1;
            if ({1'b0, issued} == LEN_M1) state <= ST_WAIT_LAST;
          end
        end
        ST_WAIT_LAST: begin
          if (last_hs) begin
            frame_cnt <= frame_cnt + 16'd1;
`ifdef AFIFO_FRAME_READER_IFG_EN
            state   <= ST_GAP;
            gap_cnt <= 8'(IFG);
`else
            state   <= ST_IDLE;
            busy    <= 1'b0;
`endif
          end
        end
`ifdef AFIFO_FRAME_READER_IFG_EN
        ST_GAP: begin
          if (gap_cnt <= 8'd1) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_frame_reader.sv
// Bench for afifo_frame_reader: FIFO model, stream scoreboard and per-scenario tasks.
// Latency: n/a.
// Backpressure: tready driven either constantly high or randomly at 50%.
module tb_afifo_frame_reader;
  import afifo_frame_reader_pkg::*;

  localparam int FL  = 64;
  localparam int IFG = 12;
`ifdef AFIFO_FRAME_READER_IFG_EN
  localparam int NEXT_GAP = IFG + 2;
`else
  localparam int NEXT_GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic [11:0] fifo_rd_data_count;
  logic        fifo_rd_en;
  logic [15:0] frame_cnt;
  logic        busy;

  afifo_frame_reader_if axis ();

  afifo_frame_reader #(.FRAME_LEN(FL), .IFG(IFG)) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_dout          (fifo_dout),
    .fifo_empty         (fifo_empty),
    .fifo_rd_data_count (fifo_rd_data_count),
    .fifo_rd_en         (fifo_rd_en),
    .m_axis             (axis),
    .frame_cnt          (frame_cnt),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bp = 1'b0;

  // FIFO model: standard-mode read data, occupancy and empty reflect contents after each edge.
  logic [7:0] fq[$];
  logic       wr_req = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       rd_en_n = 1'b0;

  always @(negedge clk) rd_en_n = rst ? 1'b0 : fifo_rd_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_dout          <= 8'h00;
      fifo_rd_data_count <= 12'd0;
      fifo_empty         <= 1'b1;
    end else begin
      if (rd_en_n && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (wr_req) fq.push_back(wr_byte);
      fifo_rd_data_count <= 12'(fq.size());
      fifo_empty         <= (fq.size() == 0);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record reads, handshakes, stall stability and bytes held inside the DUT.
  logic [7:0] exp_q[$];
  logic [7:0] bd[$];
  logic       bl[$];
  int         bc[$];
  int         rd_q[$];
  int         out_n, max_out, stab_viol, first_tv;
  logic       prev_stall, prev_l, busy_seen;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (!axis.tvalid || axis.tdata !== prev_d || axis.tlast !== prev_l)) stab_viol++;
      if (out_n > max_out) max_out = out_n;
      if (axis.tvalid && first_tv < 0) first_tv = cyc;
      if (fifo_rd_en) begin rd_q.push_back(cyc); out_n++; end
      if (axis.tvalid && axis.tready) begin
        bd.push_back(axis.tdata);
        bl.push_back(axis.tlast);
        bc.push_back(cyc);
        out_n--;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_d     = axis.tdata;
      prev_l     = axis.tlast;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    bd.delete(); bl.delete(); bc.delete(); rd_q.delete();
    out_n = 0; max_out = 0; stab_viol = 0; first_tv = -1;
    prev_stall = 1'b0; prev_l = 1'b0; prev_d = 8'h00; busy_seen = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    axis.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    clear_mon();
  endtask

  task automatic preload(input int n, input bit seq);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom_range(0, 255));
      fq.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int k = 0;
    while (bd.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (bd.size() >= n);
  endtask

  // Reference: bytes leave in write order, every FL-th byte since reset carries tlast.
  function automatic int stream_errs();
    int n = 0;
    if (bd.size() != exp_q.size()) n++;
    for (int i = 0; i < bd.size() && i < exp_q.size(); i++) begin
      if (bd[i] !== exp_q[i] || bl[i] !== ((i + 1) % FL == 0)) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    #1;
    checks++; if ({fifo_rd_en, axis.tvalid, axis.tlast, busy} !== 4'b0000 || axis.tdata !== 8'h00 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_initial rd_en=%b tvalid=%b tlast=%b busy=%b tdata=%h frame_cnt=%0d expected all 0", fifo_rd_en, axis.tvalid, axis.tlast, busy, axis.tdata, frame_cnt);
    end
    do_reset();
    preload(FL, 1'b0);
    wait_beats(5, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_warmup beats=%0d expected >=5", bd.size()); end
    rst = 1'b1;
    #1;
    checks++; if (axis.tvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_async_valid tvalid=%b rd_en=%b expected 0 0", axis.tvalid, fifo_rd_en);
    end
    checks++; if (axis.tdata !== 8'h00 || axis.tlast !== 1'b0) begin
      errors++; $display("FAIL reset_async_data tdata=%h tlast=%b expected 00 0", axis.tdata, axis.tlast);
    end
    checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_async_busy busy=%b frame_cnt=%0d expected 0 0", busy, frame_cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    do_reset();
    preload(FL, 1'b0);
    wait_beats(20, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_warmup beats=%0d expected 20", bd.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({fifo_rd_en, axis.tvalid, axis.tlast, busy} !== 4'b0000 || axis.tdata !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs rd_en=%b tvalid=%b tlast=%b busy=%b tdata=%h expected 0", fifo_rd_en, axis.tvalid, axis.tlast, busy, axis.tdata);
    end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt got=%0d expected 0", frame_cnt); end
    step(); step();
    rst = 1'b0;
    exp_q.delete();
    clear_mon();
    for (int i = 0; i < 30; i++) step();
    checks++; if (rd_q.size() != 0 || bd.size() != 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL midrst_idle reads=%0d beats=%0d busy_seen=%b expected 0 0 0", rd_q.size(), bd.size(), busy_seen);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int ne;
    do_reset();
    preload(FL, 1'b1);
    wait_beats(FL, 400, ok);
    step(); step(); step();
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout beats=%0d expected %0d", bd.size(), FL); end
    ne = stream_errs();
    checks++; if (ne != 0) begin errors++; $display("FAIL single_stream mismatches=%0d expected 0", ne); end
    checks++; if (rd_q.size() != FL) begin errors++; $display("FAIL single_rd_count got=%0d expected %0d", rd_q.size(), FL); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got=%0d expected 1", frame_cnt); end
    if (ok && rd_q.size() > 0) begin
      checks++; if (first_tv != rd_q[0] + 2) begin errors++; $display("FAIL single_tvalid_latency got=%0d expected %0d", first_tv - rd_q[0], 2); end
      checks++; if (bc[FL-1] - bc[0] != FL - 1) begin errors++; $display("FAIL single_no_bubbles span=%0d expected %0d", bc[FL-1] - bc[0], FL - 1); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b expected 0", busy); end
  endtask

  task automatic test_threshold();
    bit ok;
    int k, ne;
    do_reset();
    preload(FL - 1, 1'b0);
    for (int i = 0; i < 100; i++) step();
    checks++; if (rd_q.size() != 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL thresh_hold reads=%0d busy_seen=%b expected 0 0", rd_q.size(), busy_seen);
    end
    wr_byte = 8'($urandom_range(0, 255));
    exp_q.push_back(wr_byte);
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    k = cyc;
    wait_beats(FL, 400, ok);
    step(); step(); step();
    checks++; if (rd_q.size() == 0 || rd_q[0] != k + 1) begin
      errors++; $display("FAIL thresh_start first_rd_cycle=%0d expected %0d", (rd_q.size() > 0) ? rd_q[0] : -1, k + 1);
    end
    ne = stream_errs();
    checks++; if (!ok || ne != 0) begin errors++; $display("FAIL thresh_stream beats=%0d mismatches=%0d expected %0d 0", bd.size(), ne, FL); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL thresh_frame_cnt got=%0d expected 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int ne;
    do_reset();
    bp = 1'b1;
    preload(2 * FL, 1'b0);
    wait_beats(2 * FL, 3000, ok);
    bp = 1'b0;
    step(); step(); step();
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout beats=%0d expected %0d", bd.size(), 2 * FL); end
    ne = stream_errs();
    checks++; if (ne != 0) begin errors++; $display("FAIL bp_stream mismatches=%0d expected 0", ne); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stall_stable violations=%0d expected 0", stab_viol); end
    checks++; if (max_out > 3) begin errors++; $display("FAIL bp_occupancy max=%0d expected <=3", max_out); end
    checks++; if (rd_q.size() != 2 * FL) begin errors++; $display("FAIL bp_rd_count got=%0d expected %0d", rd_q.size(), 2 * FL); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt got=%0d expected 2", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ne;
    do_reset();
    preload(2 * FL, 1'b0);
    wait_beats(2 * FL, 800, ok);
    step(); step(); step();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout beats=%0d expected %0d", bd.size(), 2 * FL); end
    ne = stream_errs();
    checks++; if (ne != 0) begin errors++; $display("FAIL b2b_stream mismatches=%0d expected 0", ne); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt got=%0d expected 2", frame_cnt); end
    if (ok && rd_q.size() > FL) begin
      checks++; if (rd_q[FL] - bc[FL-1] != NEXT_GAP) begin
        errors++; $display("FAIL b2b_restart rd_after_tlast=%0d expected %0d", rd_q[FL] - bc[FL-1], NEXT_GAP);
      end
      checks++; if (bc[2*FL-1] - bc[FL] != FL - 1) begin
        errors++; $display("FAIL b2b_no_bubbles span=%0d expected %0d", bc[2*FL-1] - bc[FL], FL - 1);
      end
    end else begin
      checks++; errors++; $display("FAIL b2b_second_frame reads=%0d expected %0d", rd_q.size(), 2 * FL);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    clear_mon();
    test_reset();
    test_mid_frame_reset();
    test_single_frame();
    test_threshold();
    test_backpressure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/afifo_frame_reader.md
# afifo_frame_reader

Read-side consumer for the 8-bit × 4096 asynchronous byte FIFO. It runs in the FIFO's read clock domain and drains the FIFO in fixed-length frames. A frame starts only once the whole frame is already buffered. Each frame goes out as an AXI4-Stream byte stream with `tlast`, so downstream (MAC TX path) never sees an intra-frame underrun.

## Interface
Parameters:
- `FRAME_LEN`, default 64: bytes per frame; legal range 1..2048.
- `IFG`, default 12: idle cycles after each frame. Used only with the `AFIFO_FRAME_READER_IFG_EN` macro; legal range 1..255.

Ports:
- `clk` in 1: single clock, the FIFO read clock.
- `rst` in 1: asynchronous, active-high reset. The same `rst` drives the FIFO.
- `fifo_dout` in 8: FIFO read data, standard mode (valid the cycle after `rd_en` is sampled).
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_data_count` in 12: FIFO read-side occupancy.
- `fifo_rd_en` out 1: FIFO read strobe.
- `m_axis_tdata` out 8: output byte.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: marks the last byte of a frame.
- `frame_cnt` out 16: number of completed frames; wraps at 2^16.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Reset values:** state IDLE; `fifo_rd_en`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `frame_cnt`=0, `busy`=0. Issue counter, in-flight flag and output buffer are all cleared.
- **FSM states:** IDLE, READ, WAIT_LAST, GAP (GAP exists only with the macro).
- **IDLE:** when `fifo_rd_data_count >= FRAME_LEN`, go to READ. Otherwise stay.
- **READ:** `fifo_rd_en = !fifo_empty && issued < FRAME_LEN && (occ + inflight) <= 2`.
  - `occ` is the output-buffer occupancy (0..3). `inflight` is `rd_en` registered one cycle.
  - `fifo_rd_en` is a function of registers and `fifo_empty` only. There is no combinational path from `m_axis_tready`.
  - `issued` is an 11-bit counter that increments on each `fifo_rd_en`. When `issued` reaches `FRAME_LEN`, go to WAIT_LAST.
- **Capture:** in the cycle after `fifo_rd_en`, `fifo_dout` is pushed into the 3-entry output buffer. A received-byte counter tags the `FRAME_LEN`-th byte with last=1.
- **Output:** `tdata`/`tvalid`/`tlast` come from the buffer head. Pop on `tvalid && tready`.
  - While `tvalid && !tready`, `tdata` and `tlast` hold stable.
- **WAIT_LAST:** no reads. On the `tlast` handshake, `frame_cnt` increments and the FSM goes to IDLE (or to GAP with the macro).
- **Boundary cases:**
  - `FRAME_LEN`=1: every byte carries `tlast`.
  - `fifo_empty` in READ (should not occur, since the count was qualified): `rd_en` is suppressed and the FSM waits; no error.
  - The buffer never overflows, by the `occ + inflight` rule.
- **Reset mid-frame:** everything clears immediately. The partial frame is discarded and not counted; the FIFO is reset alongside.

## Timing
- First `fifo_rd_en` is asserted in the cycle after IDLE samples a qualifying count.
- First `m_axis_tvalid` rises 2 cycles after the first `fifo_rd_en` cycle.
- With `tready` held at 1, throughput is 1 byte/cycle: a frame is `FRAME_LEN` consecutive beats with no bubbles.
- Next-frame start (frames not overlapped; no prefetch):
  - Without the macro, the first `rd_en` of the next frame is sampled at the 2nd edge after the `tlast` handshake edge.
  - With the macro, it is sampled at the (`IFG`+2)th edge.

## Configuration
- `AFIFO_FRAME_READER_IFG_EN` defined: after the `tlast` handshake the FSM enters GAP, loads an 8-bit down-counter with `IFG`, and returns to IDLE when the counter reaches 0. No reads occur during GAP; `busy`=1.
- Undefined: the GAP state and counter are not compiled; WAIT_LAST goes directly to IDLE.

## Structure
- **Package `afifo_frame_reader_pkg`:**
  - State enum type.
  - Constants `DATA_W`=8, `FIFO_CNT_W`=12, `FRAME_CNT_W`=16, `OBUF_DEPTH`=3.
- **Sub-module `frame_reader_obuf`:** 3-entry, 9-bit (data + last) register FIFO with push/pop, `occ` output, and head outputs.

## Test plan
- **Reset:** assert `rst` with stimulus running → all outputs at their reset values in the same cycle, `busy`=0.
- **Single frame:** `FRAME_LEN`=64, FIFO preloaded with bytes 0x00..0x3F, `tready`=1 → 64 consecutive beats 0x00..0x3F, `tlast` only on 0x3F, exactly 64 `rd_en` pulses, `frame_cnt`=1.
- **Threshold:** count held at 63 for 100 cycles → no `rd_en` and `busy`=0. Write 1 more byte → frame starts the cycle after the count reaches 64.
- **Backpressure:** `tready` random at 50% → byte order preserved, no loss or duplication, `tdata` stable during stalls, buffer `occ` never exceeds 3.
- **Mid-frame reset:** assert `rst` after 20 beats → outputs clear immediately, `frame_cnt` unchanged from its prior value (0), state IDLE.
- **Back-to-back frames:** 128 bytes preloaded, 2 frames.
  - Without the macro: frame-2 first `rd_en` at the 2nd edge after the `tlast` handshake.
  - With the macro and `IFG`=12: at the 14th edge.
  - `frame_cnt`=2 in both cases.
